fpu_op_sequencer: RTL and testbench
===================================

# fpu_op_sequencer

Command sequencer that sits directly upstream of the FPU arithmetic peripheral core. It buffers queued {op, A, B} commands, issues them one at a time to the core using its operand/control/busy contract, and returns results in order through a result FIFO. Software or a bus bridge can therefore stream several operations without polling `busy` between them.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `RES_DEPTH`, 4: result FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO not full.
- `cmd_op`  in  2  00 NOP, 01 ADD, 10 MUL, 11 SUB (core encoding).
- `cmd_a`, `cmd_b`  in  32  IEEE-754 single operands.
- `res_valid`  out  1  result FIFO not empty.
- `res_ready`  in  1  consumer takes head result.
- `res_data`  out  32  head result (show-ahead).
- `fpu_a`, `fpu_b`  out  32  operands to core, registered.
- `fpu_op`  out  2  control to core, registered.
- `fpu_start`  out  1  one-cycle issue strobe.
- `fpu_busy`  in  1  core busy flag.
- `fpu_result`  in  32  core result register.
- `seq_idle`  out  1  FSM in IDLE and command FIFO empty.
- `seq_err`  out  1  sticky timeout flag; tied 0 when the timeout feature is compiled out.

## Operation
- Command push when `cmd_valid & cmd_ready`. `cmd_ready` = !cmd_full and does not depend on a same-cycle pop.
- Result pop when `res_valid & res_ready`. A simultaneous push and pop on the result FIFO is legal at any occupancy, including full.
- FSM states:
  - **IDLE**: if the command FIFO is non-empty and the result FIFO count < RES_DEPTH, pop the head entry.
    - op≠00: latch the entry into `fpu_a/b/op` and go to ISSUE.
    - op=00: load a captured value of 32'h0 and go to STORE. No core access; command order is preserved.
  - **ISSUE**: `fpu_start`=1 for exactly this cycle, then go to WAIT.
  - **WAIT**: `fpu_a/b/op` are held stable. When `fpu_busy`=0, capture `fpu_result` and go to STORE.
  - **STORE**: push the captured value into the result FIFO, then go to IDLE.
- Only one operation is in flight at a time. Because IDLE checks for result space, STORE can never find the result FIFO full.
- Core contract: `fpu_busy` rises on the edge that samples `fpu_start` and falls when `fpu_result` is valid. WAIT is entered on that same edge, so the first WAIT cycle already sees busy=1.
- Results are never reordered or dropped, except through reset or timeout.

## Timing
- Reset values:
  - `cmd_ready`=1
  - `res_valid`=0, `res_data`=0
  - `fpu_a`=`fpu_b`=0, `fpu_op`=0, `fpu_start`=0
  - `seq_idle`=1, `seq_err`=0
  - FSM in IDLE; both FIFOs empty.
- Reset mid-operation: the in-flight op and all queued entries are discarded immediately (asynchronous). The core is not notified; any late `fpu_busy` is ignored until the next ISSUE.
- Latency with a single-cycle-busy core and an idle sequencer: a command accepted on edge E0 appears as `res_valid`=1 after edge E5.
  - E1 pop, E2 issue, E3 core completes, E4 capture, E5 push.
  - Each additional core busy cycle adds one cycle.
- Throughput: one op per 5 cycles at minimum core latency. A NOP takes 2 cycles (IDLE, STORE).
- Counters wrap modulo depth. Occupancy uses an extra pointer bit to separate full from empty.

## Configuration
- `FPU_SEQ_TIMEOUT_EN` defined:
  - A 4-bit counter runs in WAIT.
  - If `fpu_busy` is still 1 after 15 WAIT cycles, capture 32'h7FC00000 (qNaN), go to STORE, and set `seq_err`.
  - `seq_err` clears only on `rst`.
- `FPU_SEQ_TIMEOUT_EN` undefined: WAIT has no bound, no counter is built, and `seq_err`=0 constantly.

## Test plan
- Reset, then a single ADD with a=3F800000, b=40000000 (core model returns 40400000 after 1 busy cycle) -> `fpu_start` pulses once, `res_data`=40400000 with `res_valid` rising 5 edges after accept, `seq_idle`=1 after the pop.
- Back-to-back ADD, MUL, NOP, SUB with `res_ready`=1 -> results emerge in command order; NOP yields 00000000 with no `fpu_start`; SUB drives `fpu_op`=11.
- `res_ready`=0 while 6 commands are pushed -> 4 results queued; `cmd_ready` drops after the command FIFO fills; no `fpu_start` occurs while the result FIFO is full; the remaining results drain in order once `res_ready`=1.
- Push the 4th command and pop a result in the same cycle with both FIFOs full -> the push is refused (`cmd_ready`=0), the pop succeeds, and no entry is lost or duplicated.
- Assert `rst` during WAIT with 3 commands queued -> all outputs return to their reset values asynchronously; a later busy pulse from the core produces no result.
- With `FPU_SEQ_TIMEOUT_EN`, hold `fpu_busy`=1 for 20 cycles -> after 15 WAIT cycles `res_data`=7FC00000, `seq_err`=1 (sticky), and the next command is processed normally.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// Command sequencer in front of the FPU core: queues {op,a,b}, issues one op at a time,
// returns results in order. Define FPU_SEQ_TIMEOUT_EN to bound WAIT and enable seq_err.
module fpu_op_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    output logic        fpu_start,
    input  logic        fpu_busy,
    input  logic [31:0] fpu_result,
    output logic        seq_idle,
    output logic        seq_err
);
    // state | meaning
    // IDLE  | wait for a command and result space; NOP goes straight to STORE
    // ISSUE | fpu_start high for this single cycle
    // WAIT  | operands held; wait for busy low (or timeout)
    // STORE | push captured value into the result FIFO

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [CAW:0] CMD_ONE = 1;
    localparam logic [RAW:0] RES_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

    state_t       state_q, state_d;
    logic [CAW:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [RAW:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [1:0]   cmd_op_mem_q [CMD_DEPTH];
    logic [31:0]  cmd_a_mem_q  [CMD_DEPTH];
    logic [31:0]  cmd_b_mem_q  [CMD_DEPTH];
    logic [31:0]  res_mem_q    [RES_DEPTH];
    logic [31:0]  fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [1:0]   fpu_op_q, fpu_op_d;
    logic         fpu_start_q, fpu_start_d;
    logic [31:0]  capt_q, capt_d;

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [3:0]  TMO_LOAD = 4'd14;  // reaches zero on the 15th WAIT cycle
    logic [3:0] tmo_q, tmo_d;
    logic       err_q, err_d;
`endif

    logic cmd_empty, cmd_full, res_empty, res_full;
    logic cmd_push, res_push, res_pop;

    assign cmd_empty = (cmd_wr_q == cmd_rd_q);
    assign cmd_full  = (cmd_wr_q[CAW] != cmd_rd_q[CAW]) &&
                       (cmd_wr_q[CAW-1:0] == cmd_rd_q[CAW-1:0]);
    assign res_empty = (res_wr_q == res_rd_q);
    assign res_full  = (res_wr_q[RAW] != res_rd_q[RAW]) &&
                       (res_wr_q[RAW-1:0] == res_rd_q[RAW-1:0]);

    assign cmd_push = cmd_valid && !cmd_full;
    assign res_push = (state_q == S_STORE);
    assign res_pop  = !res_empty && res_ready;

    always_comb begin
        state_d     = state_q;
        cmd_wr_d    = cmd_push ? cmd_wr_q + CMD_ONE : cmd_wr_q;
        cmd_rd_d    = cmd_rd_q;
        res_wr_d    = res_push ? res_wr_q + RES_ONE : res_wr_q;
        res_rd_d    = res_pop  ? res_rd_q + RES_ONE : res_rd_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        fpu_start_d = 1'b0;
        capt_d      = capt_q;
`ifdef FPU_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!cmd_empty && !res_full) begin
                    cmd_rd_d = cmd_rd_q + CMD_ONE;
                    if (cmd_op_mem_q[cmd_rd_q[CAW-1:0]] != 2'b00) begin
                        fpu_a_d     = cmd_a_mem_q[cmd_rd_q[CAW-1:0]];
                        fpu_b_d     = cmd_b_mem_q[cmd_rd_q[CAW-1:0]];
                        fpu_op_d    = cmd_op_mem_q[cmd_rd_q[CAW-1:0]];
                        fpu_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        capt_d  = 32'h0;
                        state_d = S_STORE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FPU_SEQ_TIMEOUT_EN
                tmo_d   = TMO_LOAD;
`endif
            end
            S_WAIT: begin
                if (!fpu_busy) begin
                    capt_d  = fpu_result;
                    state_d = S_STORE;
                end
`ifdef FPU_SEQ_TIMEOUT_EN
                else if (tmo_q == 4'd0) begin
                    capt_d  = QNAN;
                    err_d   = 1'b1;
                    state_d = S_STORE;
                end else begin
                    tmo_d = tmo_q - 4'd1;
                end
`endif
            end
            S_STORE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_wr_q    <= '0;
            cmd_rd_q    <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            fpu_start_q <= 1'b0;
            capt_q      <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cmd_op_mem_q[i] <= '0;
                cmd_a_mem_q[i]  <= '0;
                cmd_b_mem_q[i]  <= '0;
            end
            for (int i = 0; i < RES_DEPTH; i++) begin
                res_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            fpu_start_q <= fpu_start_d;
            capt_q      <= capt_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
            if (cmd_push) begin
                cmd_op_mem_q[cmd_wr_q[CAW-1:0]] <= cmd_op;
                cmd_a_mem_q[cmd_wr_q[CAW-1:0]]  <= cmd_a;
                cmd_b_mem_q[cmd_wr_q[CAW-1:0]]  <= cmd_b;
            end
            if (res_push) begin
                res_mem_q[res_wr_q[RAW-1:0]] <= capt_q;
            end
        end
    end

    assign cmd_ready = !cmd_full;
    assign res_valid = !res_empty;
    assign res_data  = res_mem_q[res_rd_q[RAW-1:0]];
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign fpu_start = fpu_start_q;
    assign seq_idle  = (state_q == S_IDLE) && cmd_empty;
`ifdef FPU_SEQ_TIMEOUT_EN
    assign seq_err   = err_q;
`else
    assign seq_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a behavioural FPU core stub.
// Timeout expectations follow FPU_SEQ_TIMEOUT_EN.
module tb_fpu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [31:0] fpu_a, fpu_b;
    logic [1:0]  fpu_op;
    logic        fpu_start;
    logic        fpu_busy = 1'b0;
    logic [31:0] fpu_result = '0;
    logic        seq_idle, seq_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int core_lat = 1;
    int core_cnt = 0;
    logic [31:0] core_pend = '0;
    logic [31:0] got_q[$];
    logic [1:0]  op_q[$];

    fpu_op_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
        .fpu_busy(fpu_busy), .fpu_result(fpu_result),
        .seq_idle(seq_idle), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] core_fn(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (op == 2'b01 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 2'b11 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        return a ^ b;
    endfunction

    // Core stub: not reset by rst, like the real core.
    always @(posedge clk) begin
        if (fpu_start) begin
            fpu_busy  <= 1'b1;
            core_cnt  <= core_lat;
            core_pend <= core_fn(fpu_op, fpu_a, fpu_b);
            start_cnt <= start_cnt + 1;
            op_q.push_back(fpu_op);
        end else if (fpu_busy) begin
            if (core_cnt <= 1) begin
                fpu_busy   <= 1'b0;
                fpu_result <= core_pend;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
        if (res_valid && res_ready) got_q.push_back(res_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int waited);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        #1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL push_timeout cmd_ready stayed %b after %0d cycles", cmd_ready, n);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        waited = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({cmd_ready, res_valid, res_data, fpu_a, fpu_b, fpu_op, fpu_start, seq_idle, seq_err}
            !== {1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b rv=%b rd=%h a=%h b=%h op=%b st=%b idle=%b err=%b",
                     cmd_ready, res_valid, res_data, fpu_a, fpu_b, fpu_op, fpu_start, seq_idle, seq_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, res_valid, fpu_start, seq_idle} !== 4'b1001) begin
            errors++;
            $display("FAIL post_reset got rdy=%b rv=%b st=%b idle=%b want 1 0 0 1",
                     cmd_ready, res_valid, fpu_start, seq_idle);
        end
    endtask

    task automatic test_single_add();
        int s0 = start_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 32'h3F800000; cmd_b = 32'h40000000;
        @(posedge clk);           // E0 accept
        #1 cmd_valid = 1'b0;
        @(posedge clk); #1;       // E1 pop -> ISSUE
        checks++;
        if (fpu_start !== 1'b1 || fpu_op !== 2'b01 || fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) begin
            errors++;
            $display("FAIL add_issue got st=%b op=%b a=%h b=%h want 1 01 3f800000 40000000",
                     fpu_start, fpu_op, fpu_a, fpu_b);
        end
        @(posedge clk); #1;       // E2 -> WAIT
        checks++;
        if (fpu_start !== 1'b0 || fpu_a !== 32'h3F800000) begin
            errors++;
            $display("FAIL add_start_width got st=%b a=%h want 0 3f800000", fpu_start, fpu_a);
        end
        @(posedge clk); #1;       // E3
        @(posedge clk); #1;       // E4 capture
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early_valid got %b want 0 after E4", res_valid);
        end
        @(posedge clk); #1;       // E5 push
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h40400000) begin
            errors++;
            $display("FAIL add_result got rv=%b data=%h want 1 40400000", res_valid, res_data);
        end
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL add_start_count got %0d want 1", start_cnt - s0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || seq_idle !== 1'b1) begin
            errors++;
            $display("FAIL add_after_pop got rv=%b idle=%b want 0 1", res_valid, seq_idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_res [4] = '{32'h40400000, 32'h40C00000, 32'h00000000, 32'h40000000};
        logic [1:0]  exp_op  [3] = '{2'b01, 2'b10, 2'b11};
        int s0 = start_cnt;
        int n = 0;
        int w;
        got_q.delete();
        op_q.delete();
        res_ready = 1'b1;
        @(negedge clk);
        push_cmd(2'b01, 32'h3F800000, 32'h40000000, w);
        push_cmd(2'b10, 32'h40000000, 32'h40400000, w);
        push_cmd(2'b00, 32'hDEADBEEF, 32'h12345678, w);
        push_cmd(2'b11, 32'h40400000, 32'h3F800000, w);
        while ((got_q.size() < 4 || !seq_idle) && n < 200) begin
            @(negedge clk);
            n++;
        end
        res_ready = 1'b0;
        checks++;
        if (got_q.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== exp_res[i]) begin
                errors++;
                $display("FAIL b2b_result[%0d] got %h want %h", i, got_q[i], exp_res[i]);
            end
        end
        checks++;
        if (start_cnt - s0 !== 3) begin
            errors++;
            $display("FAIL b2b_nop_no_start got %0d starts want 3", start_cnt - s0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (op_q[i] !== exp_op[i]) begin
                errors++;
                $display("FAIL b2b_fpu_op[%0d] got %b want %b", i, op_q[i], exp_op[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int s0 = start_cnt;
        int waits = 0;
        int w;
        int n = 0;
        got_q.delete();
        res_ready = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            push_cmd(2'b01, 32'h10000000 + i, 32'h00000100, w);
            waits += w;
        end
        checks++;
        if (waits == 0) begin
            errors++;
            $display("FAIL bp_cmd_ready_drop got waits=%0d want >0", waits);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 4) begin
            errors++;
            $display("FAIL bp_start_while_full got %0d starts want 4", start_cnt - s0);
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h10000101 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_head got rv=%b data=%h rdy=%b want 1 10000101 1", res_valid, res_data, cmd_ready);
        end
        push_cmd(2'b01, 32'h10000007, 32'h00000100, w);
        push_cmd(2'b01, 32'h10000008, 32'h00000100, w);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_both_full got rdy=%b rv=%b want 0 1", cmd_ready, res_valid);
        end
        // Offer a push and take a pop on the same edge with both FIFOs full.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 32'h10000009; cmd_b = 32'h00000100;
        res_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; res_ready = 1'b0;
        checks++;
        if (res_data !== 32'h10000102) begin
            errors++;
            $display("FAIL bp_simul_pop got head %h want 10000102", res_data);
        end
        push_cmd(2'b01, 32'h10000009, 32'h00000100, w);
        res_ready = 1'b1;
        while ((got_q.size() < 9 || !seq_idle || res_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        res_ready = 1'b0;
        checks++;
        if (got_q.size() !== 9) begin
            errors++;
            $display("FAIL bp_count got %0d want 9", got_q.size());
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got_q[i] !== 32'h10000101 + i) begin
                errors++;
                $display("FAIL bp_order[%0d] got %h want %h", i, got_q[i], 32'h10000101 + i);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int s0;
        int w;
        core_lat = 10;
        res_ready = 1'b0;
        s0 = start_cnt;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) push_cmd(2'b01, 32'h20000000 + i, 32'h1, w);
        @(negedge clk);
        checks++;
        if (seq_idle !== 1'b0 || fpu_a !== 32'h20000001 || fpu_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got idle=%b a=%h busy=%b want 0 20000001 1", seq_idle, fpu_a, fpu_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, res_valid, res_data, fpu_a, fpu_b, fpu_op, fpu_start, seq_idle, seq_err}
            !== {1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_async got rdy=%b rv=%b rd=%h a=%h b=%h op=%b st=%b idle=%b err=%b",
                     cmd_ready, res_valid, res_data, fpu_a, fpu_b, fpu_op, fpu_start, seq_idle, seq_err);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || seq_idle !== 1'b1 || start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL rst_late_busy got rv=%b idle=%b starts=%0d want 0 1 1",
                     res_valid, seq_idle, start_cnt - s0);
        end
        core_lat = 1;
    endtask

    task automatic test_timeout();
        int n = 0;
        int w;
        core_lat = 20;
        @(negedge clk);
        push_cmd(2'b01, 32'h3F800000, 32'h40000000, w);
        while (!res_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
`ifdef FPU_SEQ_TIMEOUT_EN
        checks++;
        if (res_data !== 32'h7FC00000 || seq_err !== 1'b1 || n !== 19) begin
            errors++;
            $display("FAIL tmo_result got data=%h err=%b n=%0d want 7fc00000 1 19", res_data, seq_err, n);
        end
`else
        checks++;
        if (res_data !== 32'h40400000 || seq_err !== 1'b0 || n !== 25) begin
            errors++;
            $display("FAIL long_busy_result got data=%h err=%b n=%0d want 40400000 0 25", res_data, seq_err, n);
        end
`endif
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        n = 0;
        while (fpu_busy && n < 80) begin
            @(negedge clk);
            n++;
        end
        core_lat = 1;
        push_cmd(2'b11, 32'h40400000, 32'h3F800000, w);
        n = 0;
        while (!res_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
`ifdef FPU_SEQ_TIMEOUT_EN
        checks++;
        if (res_data !== 32'h40000000 || seq_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_next got data=%h err=%b want 40000000 1", res_data, seq_err);
        end
`else
        checks++;
        if (res_data !== 32'h40000000 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL long_busy_next got data=%h err=%b want 40000000 0", res_data, seq_err);
        end
`endif
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
